// File: rtl/memory_stage_if.sv
// Data bus between the memory stage and the data memory/cache.
// The master issues requests; the slave answers with a one-cycle ack carrying read data.
interface memory_stage_if;
  logic        dbus_req;
  logic        dbus_we;
  logic [29:0] dbus_addr;
  logic [3:0]  dbus_be;
  logic [31:0] dbus_wdata;
  logic        dbus_ack;
  logic [31:0] dbus_rdata;

  modport master (
    output dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata,
    input  dbus_ack, dbus_rdata
  );

  modport slave (
    input  dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata,
    output dbus_ack, dbus_rdata
  );
endinterface

// File: rtl/memory_stage.sv
// Pipeline memory stage: issues loads/stores on the data bus, stalls until ack,
// formats load data and produces the writeback register set.
module memory_stage (
  input  logic                 clk,
  input  logic                 sync_rst,
  input  logic                 clk_en,
  input  logic [4:0]           ctr_in,
  input  logic [31:0]          inst_in,
  input  logic [31:0]          alu_in,
  input  logic [29:0]          inc_pc_in,
  input  logic [31:0]          rs2_data_in,
  input  logic                 branch_result_in,
  output logic                 redirect_valid,
  output logic [29:0]          redirect_pc,
  output logic                 stall_out,
  memory_stage_if.master       dbus,
  output logic                 misalign_err,
  output logic                 wb_we,
  output logic [4:0]           wb_rd,
  output logic [31:0]          wb_data,
  output logic [4:0]           mem_rd_address,
  output logic                 mem_writes_rd
);
  localparam int unsigned XLEN = 32;
  localparam int unsigned PCW  = 30;

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  state_t state_q, state_d;

  logic [2:0]      fn3;
  logic [4:0]      rd;
  logic            mem_op;
  logic            misaligned;
  logic [3:0]      be_c;
  logic [XLEN-1:0] wdata_c;
  logic [XLEN-1:0] sel_data_c;
  logic [XLEN-1:0] ld_data_c;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;

  logic [PCW-1:0]  lat_addr;
  logic [3:0]      lat_be;
  logic [XLEN-1:0] lat_wdata;
  logic            lat_we;
  logic [2:0]      lat_fn3;
  logic [1:0]      lat_off;
  logic [4:0]      lat_rd;
  logic            lat_rw;

  logic            unused_inst_bits;

  assign fn3    = inst_in[14:12];
  assign rd     = inst_in[11:7];
  assign mem_op = ctr_in[1] | ctr_in[2];
  assign unused_inst_bits = ^{inst_in[31:15], inst_in[6:0]};

  // Access size comes from fn3[1:0]: byte, half, word (encoding 3 handled as word).
  always_comb begin
    misaligned = 1'b0;
    be_c       = 4'b1111;
    wdata_c    = rs2_data_in;
    case (fn3[1:0])
      2'b00: begin
        be_c    = 4'(4'b0001 << alu_in[1:0]);
        wdata_c = {4{rs2_data_in[7:0]}};
      end
      2'b01: begin
        misaligned = alu_in[0];
        be_c       = 4'(4'b0011 << {alu_in[1], 1'b0});
        wdata_c    = {2{rs2_data_in[15:0]}};
      end
      default: misaligned = |alu_in[1:0];
    endcase
  end

  always_comb begin
    case (ctr_in[4:3])
      2'b01:   sel_data_c = dbus.dbus_rdata;
      2'b10:   sel_data_c = XLEN'(inc_pc_in);
      default: sel_data_c = alu_in;
    endcase
  end

  // Load formatting uses the byte offset captured when the access started.
  always_comb begin
    ld_byte = dbus.dbus_rdata[7:0];
    case (lat_off)
      2'd1:    ld_byte = dbus.dbus_rdata[15:8];
      2'd2:    ld_byte = dbus.dbus_rdata[23:16];
      2'd3:    ld_byte = dbus.dbus_rdata[31:24];
      default: ld_byte = dbus.dbus_rdata[7:0];
    endcase
    ld_half = lat_off[1] ? dbus.dbus_rdata[31:16] : dbus.dbus_rdata[15:0];
    case (lat_fn3)
      3'b000:  ld_data_c = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_data_c = {24'd0, ld_byte};
      3'b001:  ld_data_c = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_data_c = {16'd0, ld_half};
      default: ld_data_c = dbus.dbus_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sync_rst) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (clk_en && mem_op && !misaligned) state_d = ACCESS;
      ACCESS:  if (clk_en && dbus.dbus_ack)         state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stall_out     = 1'b0;
    dbus.dbus_req = 1'b0;
    case (state_q)
      IDLE:    stall_out = mem_op & ~misaligned;
      ACCESS: begin
        dbus.dbus_req = 1'b1;
        stall_out     = ~dbus.dbus_ack;
      end
      default: stall_out = 1'b0;
    endcase
  end

  assign dbus.dbus_addr  = lat_addr;
  assign dbus.dbus_be    = lat_be;
  assign dbus.dbus_wdata = lat_wdata;
  assign dbus.dbus_we    = lat_we;

  assign redirect_valid = branch_result_in & ~stall_out;
  assign redirect_pc    = alu_in[31:2];
  assign mem_rd_address = rd;
  assign mem_writes_rd  = ctr_in[0] & (rd != 5'd0);

  // Access latches and writeback registers.
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      wb_we        <= 1'b0;
      wb_rd        <= 5'd0;
      wb_data      <= '0;
      misalign_err <= 1'b0;
      lat_addr     <= '0;
      lat_be       <= '0;
      lat_wdata    <= '0;
      lat_we       <= 1'b0;
      lat_fn3      <= '0;
      lat_off      <= '0;
      lat_rd       <= '0;
      lat_rw       <= 1'b0;
    end else if (clk_en) begin
      misalign_err <= 1'b0;
      if (state_q == IDLE) begin
        if (mem_op) begin
          wb_we <= 1'b0;
          if (misaligned) begin
            misalign_err <= 1'b1;
          end else begin
            lat_addr  <= alu_in[31:2];
            lat_be    <= ctr_in[2] ? be_c : 4'b1111;
            lat_wdata <= wdata_c;
            lat_we    <= ctr_in[2];
            lat_fn3   <= fn3;
            lat_off   <= alu_in[1:0];
            lat_rd    <= rd;
            lat_rw    <= ctr_in[0];
          end
        end else begin
          wb_we   <= ctr_in[0] & (rd != 5'd0);
          wb_rd   <= rd;
          wb_data <= sel_data_c;
        end
      end else if (dbus.dbus_ack) begin
        wb_we   <= ~lat_we & lat_rw & (lat_rd != 5'd0);
        wb_rd   <= lat_rd;
        wb_data <= ld_data_c;
      end else begin
        wb_we <= 1'b0;
      end
    end
  end
endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 clk  in  1  sole clock; all state updates on its rising edge.
REQ-002 sync_rst  in  1  reset, synchronous, active-high.
REQ-003 clk_en  in  1  global pipeline advance enable; no state changes while low.
REQ-004 ctr_in  in  5  from execute: [0] reg_write, [1] mem_read, [2] mem_write, [4:3] wb_sel (0 ALU, 1 load data, 2 incremented PC, 3 reserved, treated as 0).
REQ-005 inst_in  in  32  buffered instruction; fn3 = [14:12], rd = [11:7].
REQ-006 alu_in  in  32  ALU result; this is the memory byte address for loads and stores.
REQ-007 inc_pc_in  in  30  incremented word PC.
REQ-008 rs2_data_in  in  32  store data.
REQ-009 branch_result_in  in  1  taken branch or jump.
REQ-010 redirect_valid / redirect_pc  out  1 / 30  fetch redirect; redirect_pc = alu_in[31:2].
REQ-011 stall_out  out  1  requests upstream hold.
REQ-012 dbus_req, dbus_we  out  1 each  request and write strobe.
REQ-013 dbus_addr  out  30  word address.
REQ-014 dbus_be  out  4  byte enables.
REQ-015 dbus_wdata  out  32  store data.
REQ-016 dbus_ack  in  1  one-cycle completion pulse.
REQ-017 dbus_rdata  in  32  read data; valid with dbus_ack.
REQ-018 misalign_err  out  1  one-cycle error pulse.
REQ-019 wb_we  out  1  writeback enable.
REQ-020 wb_rd  out  5  writeback destination register.
REQ-021 wb_data  out  32  writeback data.
REQ-022 mem_rd_address, mem_writes_rd  out  5, 1  hazard/forwarding info; mem_writes_rd = ctr_in[0] and rd != 0.

Function
REQ-023 Memory op (mem_op) shall be ctr_in[1] or ctr_in[2]; mem_write shall take priority if both are set.
REQ-024 FSM states shall be IDLE and ACCESS.
REQ-025 IDLE, clk_en, aligned mem_op: latch addr/be/wdata/we/fn3/addr[1:0]/rd/reg_write, go ACCESS; stall_out high combinationally that cycle.
REQ-026 ACCESS: dbus_req = 1; dbus_addr/be/wdata/we driven from latches; stall_out = !dbus_ack.
REQ-027 ACCESS with dbus_ack and clk_en: return IDLE; load writeback registers (load: extended data, we = latched reg_write; store: we = 0).
REQ-028 Byte enables: SB 4'b0001 << addr[1:0]; SH 4'b0011 << {addr[1],0}; SW 4'b1111. Store data: byte replicated x4, half replicated x2, word as-is.
REQ-029 Load extension by fn3: LB/LH sign-extend, LBU/LHU zero-extend, LW raw; byte/half selected by latched addr[1:0].
REQ-030 Misaligned access: half with addr[0] = 1, or word with addr[1:0] != 0. Response: no bus request, misalign_err pulses one cycle, no stall, bubble to writeback.
REQ-031 Non-memory instruction in IDLE with clk_en: single-cycle; wb_we = ctr_in[0]; wb_data selected by wb_sel; wb_rd = inst_in[11:7].
REQ-032 wb_we shall be forced 0 when rd = 0.
REQ-033 Cycles with stall_out high shall load a bubble (wb_we = 0) into writeback, except the ack cycle.
REQ-034 redirect_valid = branch_result_in and not stalled; combinational.
REQ-035 clk_en low: FSM and all registers hold; dbus outputs stay stable in ACCESS.
REQ-036 A dbus_ack arriving in IDLE shall be ignored.

Reset
REQ-037 sync_rst shall take priority over clk_en.
REQ-038 sync_rst shall force: state IDLE; wb_we 0; wb_rd 0; wb_data 0; misalign_err 0; dbus_req 0. An outstanding access is abandoned and any later ack ignored.

Verification
REQ-039 ADD rd = 5, wb_sel 0, alu_in = 0x1234 -> next cycle wb_we = 1, wb_rd = 5, wb_data = 0x1234; stall_out never high.
REQ-040 LB, alu_in = 0x103, dbus_rdata = 0x80000000, ack after 3 cycles -> dbus_addr = 0x40, stall_out high 4 cycles, wb_data = 0xFFFFFF80; repeat with LBU -> 0x00000080.
REQ-041 SH, alu_in = 0x202, rs2 = 0xABCD -> dbus_we = 1, dbus_be = 4'b1100, dbus_wdata = 0xABCDABCD, wb_we = 0 after ack.
REQ-042 LW, alu_in = 0x6 -> misalign_err pulses once, dbus_req stays 0, wb_we = 0.
REQ-043 JAL, branch_result_in = 1, alu_in = 0x80, wb_sel 2, inc_pc_in = 0x11 -> redirect_valid = 1, redirect_pc = 0x20, wb_data = 0x11.
REQ-044 sync_rst during ACCESS, then late dbus_ack -> IDLE, dbus_req = 0, no writeback.
